pipeline_control_unit: RTL and testbench

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

---
 rtl/pipeline_control_unit_if.sv | 60 ++++++
 rtl/pipeline_control_unit.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_pipeline_control_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_control_unit_if.sv
// Bundle of signals between the datapath and the pipeline control unit.
//
// Carries:
//   instruction_out          ID-stage instruction word
//   instr_one_clock_before   EX-stage instruction word
//   instr_two_clocks_before  MEM-stage instruction word
//   ALUFlags                 {N,Z,C,V} produced in EX this cycle
//   IsRegRdZero              ID-stage CBZ operand equals zero
//   ID controls              Reg2Loc/UnCondBr/BrTaken and forwarding selects
//   EX controls              AluSrc/IsImm/ALUOp/ALURes
//   MEM controls             WrEnable/RdEnable/MemReg
//   WB control               RegWrite
//   status                   load_use_hazard, illegal_instr, flags_q
//
// The datapath uses the master modport; the control unit uses slave.
interface pipeline_control_unit_if;
    logic [31:0] instruction_out;
    logic [31:0] instr_one_clock_before;
    logic [31:0] instr_two_clocks_before;
    logic [3:0]  ALUFlags;
    logic        IsRegRdZero;

    logic        Reg2Loc_Ctrl;
    logic        UnCondBr_Ctrl;
    logic        BrTaken_Ctrl;
    logic [1:0]  FW_RegFile1_Ctrl;
    logic [1:0]  FW_RegFile2_Ctrl;

    logic        AluSrc_Ctrl;
    logic        IsImm_Ctrl;
    logic [2:0]  ALUOp_Ctrl;
    logic [1:0]  ALURes_Ctrl;

    logic        WrEnable_Ctrl;
    logic        RdEnable_Ctrl;
    logic        MemReg_Ctrl;
    logic        RegWrite_Ctrl;

    logic        load_use_hazard;
    logic        illegal_instr;
    logic [3:0]  flags_q;

    modport master (
        output instruction_out, instr_one_clock_before, instr_two_clocks_before,
               ALUFlags, IsRegRdZero,
        input  Reg2Loc_Ctrl, UnCondBr_Ctrl, BrTaken_Ctrl, FW_RegFile1_Ctrl, FW_RegFile2_Ctrl,
               AluSrc_Ctrl, IsImm_Ctrl, ALUOp_Ctrl, ALURes_Ctrl,
               WrEnable_Ctrl, RdEnable_Ctrl, MemReg_Ctrl, RegWrite_Ctrl,
               load_use_hazard, illegal_instr, flags_q
    );

    modport slave (
        input  instruction_out, instr_one_clock_before, instr_two_clocks_before,
               ALUFlags, IsRegRdZero,
        output Reg2Loc_Ctrl, UnCondBr_Ctrl, BrTaken_Ctrl, FW_RegFile1_Ctrl, FW_RegFile2_Ctrl,
               AluSrc_Ctrl, IsImm_Ctrl, ALUOp_Ctrl, ALURes_Ctrl,
               WrEnable_Ctrl, RdEnable_Ctrl, MemReg_Ctrl, RegWrite_Ctrl,
               load_use_hazard, illegal_instr, flags_q
    );
endinterface

// File: rtl/pipeline_control_unit.sv
// Control unit for a 5-stage ARM-subset (LEGv8-like) pipeline.
//
// Decodes the ID-stage instruction and produces:
//   - ID controls combinationally (Reg2Loc, branch select/taken, forwarding
//     selects for both register-file read ports, load-use hazard flag);
//   - EX/MEM/WB controls from a 1/2/3-deep register chain of the ID decode;
//   - a one-cycle illegal_instr pulse for unmatched non-zero words;
//   - flags_q, the {N,Z,C,V} captured whenever ADDS/SUBS is in EX.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (clears all registered state)
//   bus    pipeline_control_unit_if.slave, see the interface file
//
// Forwarding selects: 00 register file, 01 from EX result, 10 from MEM result.
// Branches have one delay slot, so nothing is ever flushed here.
module pipeline_control_unit (
    input  logic                          clk,
    input  logic                          reset,
    pipeline_control_unit_if.slave        bus
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADDI = 4'd1,
        OP_ADDS = 4'd2,
        OP_SUBS = 4'd3,
        OP_LDUR = 4'd4,
        OP_STUR = 4'd5,
        OP_B    = 4'd6,
        OP_BLT  = 4'd7,
        OP_CBZ  = 4'd8,
        OP_ILL  = 4'd9
    } op_e;

    typedef struct packed {
        logic       alu_src;
        logic       is_imm;
        logic [2:0] alu_op;
        logic [1:0] alu_res;
        logic       wr_en;
        logic       rd_en;
        logic       mem_reg;
        logic       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic wr_en;
        logic rd_en;
        logic mem_reg;
        logic reg_write;
    } mem_ctrl_t;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [1:0] RES_ALU    = 2'b00;
    localparam logic [4:0] XZR        = 5'd31;
    localparam logic [1:0] FW_RF      = 2'b00;
    localparam logic [1:0] FW_EX      = 2'b01;
    localparam logic [1:0] FW_MEM     = 2'b10;

    localparam ctrl_t     CTRL_NOP = 11'b000_0000_0000;
    localparam mem_ctrl_t MEM_NOP  = 4'b0000;

    // Classify an instruction word; zero is a NOP, anything unmatched is illegal.
    function automatic op_e decode_op(input logic [31:0] w);
        op_e op;
        if (w == 32'h0000_0000) begin
            op = OP_NOP;
        end else if (w[31:22] == 10'b1001000100) begin
            op = OP_ADDI;
        end else if (w[31:21] == 11'b10101011000) begin
            op = OP_ADDS;
        end else if (w[31:21] == 11'b11101011000) begin
            op = OP_SUBS;
        end else if (w[31:21] == 11'b11111000010) begin
            op = OP_LDUR;
        end else if (w[31:21] == 11'b11111000000) begin
            op = OP_STUR;
        end else if (w[31:26] == 6'b000101) begin
            op = OP_B;
        end else if ((w[31:24] == 8'b01010100) && (w[4:0] == 5'b01011)) begin
            op = OP_BLT;
        end else if (w[31:24] == 8'b10110100) begin
            op = OP_CBZ;
        end else begin
            op = OP_ILL;
        end
        return op;
    endfunction

    // EX/MEM/WB control word carried down the pipe for one decoded op.
    function automatic ctrl_t ctrl_of(input op_e op);
        ctrl_t c;
        c         = CTRL_NOP;
        c.alu_op  = ALU_PASS_B;
        c.alu_res = RES_ALU;
        case (op)
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.is_imm    = 1'b1;
                c.alu_op    = ALU_ADD;
                c.reg_write = 1'b1;
            end
            OP_ADDS: begin
                c.alu_op    = ALU_ADD;
                c.reg_write = 1'b1;
            end
            OP_SUBS: begin
                c.alu_op    = ALU_SUB;
                c.reg_write = 1'b1;
            end
            OP_LDUR: begin
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_ADD;
                c.rd_en     = 1'b1;
                c.mem_reg   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_STUR: begin
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_ADD;
                c.wr_en     = 1'b1;
            end
            default: begin
                c = CTRL_NOP;
            end
        endcase
        return c;
    endfunction

    // An op that writes a real register (X31 writes are discarded).
    function automatic logic is_writer(input op_e op, input logic [4:0] rd);
        logic wr;
        case (op)
            OP_ADDI, OP_ADDS, OP_SUBS, OP_LDUR: wr = (rd != XZR);
            default:                            wr = 1'b0;
        endcase
        return wr;
    endfunction

    // Forwarding select for one source. A load in EX has no result yet, so it
    // blocks forwarding entirely (the hazard flag covers that case) rather
    // than letting an older MEM value through.
    function automatic logic [1:0] fw_sel(
        input logic       used,
        input logic [4:0] src,
        input op_e        ex_op,
        input logic [4:0] ex_rd,
        input op_e        mem_op,
        input logic [4:0] mem_rd
    );
        logic [1:0] sel;
        if (!used || (src == XZR)) begin
            sel = FW_RF;
        end else if (is_writer(ex_op, ex_rd) && (ex_rd == src)) begin
            if (ex_op == OP_LDUR) begin
                sel = FW_RF;
            end else begin
                sel = FW_EX;
            end
        end else if (is_writer(mem_op, mem_rd) && (mem_rd == src)) begin
            sel = FW_MEM;
        end else begin
            sel = FW_RF;
        end
        return sel;
    endfunction

    op_e        id_op_s;
    op_e        ex_op_s;
    op_e        mem_op_s;
    logic [4:0] ex_rd_s;
    logic [4:0] mem_rd_s;
    logic [4:0] rn_s;
    logic [4:0] src2_s;
    logic       use_rn_s;
    logic       use_src2_s;
    logic       reg2loc_s;
    logic       uncond_s;
    logic       br_taken_s;
    logic       ex_sets_flags_s;
    logic       eff_n_s;
    logic       eff_v_s;
    logic [1:0] fw1_s;
    logic [1:0] fw2_s;
    logic       hazard_s;

    ctrl_t      ex_d,        ex_q;
    mem_ctrl_t  mem_d,       mem_q;
    logic       reg_write_d, reg_write_q;
    logic       illegal_d,   illegal_q;
    logic [3:0] flags_d,     flags_q;

    // Decode all three visible pipeline stages.
    always_comb begin
        id_op_s  = decode_op(bus.instruction_out);
        ex_op_s  = decode_op(bus.instr_one_clock_before);
        mem_op_s = decode_op(bus.instr_two_clocks_before);
        ex_rd_s  = bus.instr_one_clock_before[4:0];
        mem_rd_s = bus.instr_two_clocks_before[4:0];
    end

    // Register-port selection and which sources the ID instruction reads.
    always_comb begin
        reg2loc_s = (id_op_s == OP_ADDS) || (id_op_s == OP_SUBS);
        rn_s      = bus.instruction_out[9:5];
        if (reg2loc_s) begin
            src2_s = bus.instruction_out[20:16];
        end else begin
            src2_s = bus.instruction_out[4:0];
        end
        case (id_op_s)
            OP_ADDI, OP_LDUR: begin
                use_rn_s   = 1'b1;
                use_src2_s = 1'b0;
            end
            OP_ADDS, OP_SUBS, OP_STUR: begin
                use_rn_s   = 1'b1;
                use_src2_s = 1'b1;
            end
            OP_CBZ: begin
                use_rn_s   = 1'b0;
                use_src2_s = 1'b1;
            end
            default: begin
                use_rn_s   = 1'b0;
                use_src2_s = 1'b0;
            end
        endcase
    end

    // Branch resolution; flags from an ADDS/SUBS still in EX are used live.
    always_comb begin
        ex_sets_flags_s = (ex_op_s == OP_ADDS) || (ex_op_s == OP_SUBS);
        uncond_s        = (id_op_s == OP_B);
        if (ex_sets_flags_s) begin
            eff_n_s = bus.ALUFlags[3];
            eff_v_s = bus.ALUFlags[0];
        end else begin
            eff_n_s = flags_q[3];
            eff_v_s = flags_q[0];
        end
        case (id_op_s)
            OP_B:    br_taken_s = 1'b1;
            OP_CBZ:  br_taken_s = bus.IsRegRdZero;
            OP_BLT:  br_taken_s = eff_n_s ^ eff_v_s;
            default: br_taken_s = 1'b0;
        endcase
    end

    // Forwarding selects and load-use detection.
    always_comb begin
        fw1_s    = fw_sel(use_rn_s,   rn_s,   ex_op_s, ex_rd_s, mem_op_s, mem_rd_s);
        fw2_s    = fw_sel(use_src2_s, src2_s, ex_op_s, ex_rd_s, mem_op_s, mem_rd_s);
        hazard_s = (ex_op_s == OP_LDUR) && (ex_rd_s != XZR) &&
                   ((use_rn_s && (rn_s == ex_rd_s)) || (use_src2_s && (src2_s == ex_rd_s)));
    end

    // Next-state for the stage registers, illegal pulse and stored flags.
    always_comb begin
        ex_d        = ctrl_of(id_op_s);
        mem_d       = {ex_q.wr_en, ex_q.rd_en, ex_q.mem_reg, ex_q.reg_write};
        reg_write_d = mem_q.reg_write;
        illegal_d   = (id_op_s == OP_ILL);
        if (ex_sets_flags_s) begin
            flags_d = bus.ALUFlags;
        end else begin
            flags_d = flags_q;
        end
    end

    // Stage registers; reset drops every in-flight control.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= CTRL_NOP;
            mem_q       <= MEM_NOP;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
            flags_q     <= 4'b0000;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.Reg2Loc_Ctrl     = reg2loc_s;
    assign bus.UnCondBr_Ctrl    = uncond_s;
    assign bus.BrTaken_Ctrl     = br_taken_s;
    assign bus.FW_RegFile1_Ctrl = fw1_s;
    assign bus.FW_RegFile2_Ctrl = fw2_s;
    assign bus.load_use_hazard  = hazard_s;

    assign bus.AluSrc_Ctrl      = ex_q.alu_src;
    assign bus.IsImm_Ctrl       = ex_q.is_imm;
    assign bus.ALUOp_Ctrl       = ex_q.alu_op;
    assign bus.ALURes_Ctrl      = ex_q.alu_res;

    assign bus.WrEnable_Ctrl    = mem_q.wr_en;
    assign bus.RdEnable_Ctrl    = mem_q.rd_en;
    assign bus.MemReg_Ctrl      = mem_q.mem_reg;
    assign bus.RegWrite_Ctrl    = reg_write_q;

    assign bus.illegal_instr    = illegal_q;
    assign bus.flags_q          = flags_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed-stimulus bench for pipeline_control_unit. A cycle-indexed record of
// every instruction issued to ID is kept; expected outputs are derived from it
// with instruction-level rules, and literal expectations pin key cycles.
module tb_pipeline_control_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_control_unit_if bus();
    pipeline_control_unit dut (.clk(clk), .reset(reset), .bus(bus));

    localparam int K_NOP = 0, K_ADDI = 1, K_ADDS = 2, K_SUBS = 3, K_LDUR = 4;
    localparam int K_STUR = 5, K_B = 6, K_BLT = 7, K_CBZ = 8, K_ILL = 9;
    localparam int NCYC = 64;
    localparam logic [3:0] D = 4'b0010;

    logic [31:0] id_w  [NCYC];
    logic [31:0] ex_w  [NCYC];
    logic [31:0] mem_w [NCYC];
    logic [3:0]  alu_f [NCYC];
    logic        zero_f[NCYC];
    logic        rst_f [NCYC];

    int          cur = 0;
    int          n = 0;
    int          errors = 0;
    int          checks = 0;
    bit          active = 1'b0;
    logic [3:0]  flags_m = 4'b0000;
    logic [31:0] p1 = 32'h0;
    logic [31:0] p2 = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cur, act, exp);
        end
    endtask

    function automatic int kind(input logic [31:0] w);
        int k;
        if (w == 32'h0) return K_NOP;
        casez (w)
            32'b1001000100_??????????_??????????_??:  k = K_ADDI;
            32'b10101011000_??????????_??????????_?:  k = K_ADDS;
            32'b11101011000_??????????_??????????_?:  k = K_SUBS;
            32'b11111000010_??????????_??????????_?:  k = K_LDUR;
            32'b11111000000_??????????_??????????_?:  k = K_STUR;
            32'b000101_??????????_??????????_??????:  k = K_B;
            32'b01010100_??????????_?????????_01011:  k = K_BLT;
            32'b10110100_??????????_??????????_????:  k = K_CBZ;
            default:                                  k = K_ILL;
        endcase
        return k;
    endfunction

    // {AluSrc, IsImm, ALUOp[2:0], ALURes[1:0], WrEnable, RdEnable, MemReg, RegWrite}
    function automatic logic [10:0] ctrl(input int k);
        case (k)
            K_ADDI:  return 11'b1_1_010_00_0_0_0_1;
            K_ADDS:  return 11'b0_0_010_00_0_0_0_1;
            K_SUBS:  return 11'b0_0_011_00_0_0_0_1;
            K_LDUR:  return 11'b1_0_010_00_0_1_1_1;
            K_STUR:  return 11'b1_0_010_00_1_0_0_0;
            default: return 11'b0;
        endcase
    endfunction

    function automatic bit writes(input logic [31:0] w);
        int k;
        k = kind(w);
        return ((k == K_ADDI) || (k == K_ADDS) || (k == K_SUBS) || (k == K_LDUR)) && (w[4:0] != 5'd31);
    endfunction

    function automatic logic [1:0] fw_model(input bit used, input logic [4:0] s,
                                            input logic [31:0] e, input logic [31:0] m);
        if (!used || s == 5'd31) return 2'b00;
        if (writes(e) && e[4:0] == s) return (kind(e) == K_LDUR) ? 2'b00 : 2'b01;
        if (writes(m) && m[4:0] == s) return 2'b10;
        return 2'b00;
    endfunction

    // instruction issued n cycles ago still in flight (no reset since then)
    function automatic bit live(input int c, input int d);
        for (int i = 1; i <= d; i++) begin
            if (c - i < 0) return 1'b0;
            if (rst_f[c - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rn, input logic [11:0] imm);
        return {10'b1001000100, imm, rn, rd};
    endfunction
    function automatic logic [31:0] enc_r(input bit sub, input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {(sub ? 11'b11101011000 : 11'b10101011000), rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_ldur(input logic [4:0] rt, input logic [4:0] rn, input logic [8:0] off);
        return {11'b11111000010, off, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_stur(input logic [4:0] rt, input logic [4:0] rn, input logic [8:0] off);
        return {11'b11111000000, off, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_bcond(input logic [4:0] cond);
        return {8'b01010100, 19'd2, cond};
    endfunction
    function automatic logic [31:0] enc_cbz(input logic [4:0] rt);
        return {8'b10110100, 19'd3, rt};
    endfunction

    task automatic step(input logic [31:0] w, input logic [3:0] f, input logic z, input logic r);
        @(posedge clk);
        #1;
        cur       = n;
        id_w[n]   = w;
        ex_w[n]   = p1;
        mem_w[n]  = p2;
        alu_f[n]  = f;
        zero_f[n] = z;
        rst_f[n]  = r;
        bus.instruction_out         = w;
        bus.instr_one_clock_before  = p1;
        bus.instr_two_clocks_before = p2;
        bus.ALUFlags                = f;
        bus.IsRegRdZero             = z;
        reset                       = r;
        p2 = p1;
        p1 = w;
        n++;
        active = 1'b1;
        @(negedge clk);
        #1;
    endtask

    // Per-cycle comparison of every output against the instruction-level model.
    always @(negedge clk) begin : compare
        int          kw, ke, c;
        logic [4:0]  s2;
        bit          u1, u2, haz, br, en, ev;
        logic [10:0] ce, cm;
        logic        cw, ill;
        if (active && cur >= 1) begin
            c  = cur;
            kw = kind(id_w[c]);
            ke = kind(ex_w[c]);
            u1 = (kw == K_ADDI) || (kw == K_LDUR) || (kw == K_ADDS) || (kw == K_SUBS) || (kw == K_STUR);
            u2 = (kw == K_ADDS) || (kw == K_SUBS) || (kw == K_STUR) || (kw == K_CBZ);
            s2 = ((kw == K_ADDS) || (kw == K_SUBS)) ? id_w[c][20:16] : id_w[c][4:0];
            haz = (ke == K_LDUR) && (ex_w[c][4:0] != 5'd31) &&
                  ((u1 && id_w[c][9:5] == ex_w[c][4:0]) || (u2 && s2 == ex_w[c][4:0]));
            en = ((ke == K_ADDS) || (ke == K_SUBS)) ? alu_f[c][3] : flags_m[3];
            ev = ((ke == K_ADDS) || (ke == K_SUBS)) ? alu_f[c][0] : flags_m[0];
            br = (kw == K_B) || (kw == K_CBZ && zero_f[c]) || (kw == K_BLT && (en ^ ev));
            ce  = live(c, 1) ? ctrl(kind(id_w[c - 1])) : 11'b0;
            cm  = live(c, 2) ? ctrl(kind(id_w[c - 2])) : 11'b0;
            cw  = live(c, 3) ? ctrl(kind(id_w[c - 3]))[0] : 1'b0;
            ill = live(c, 1) && (kind(id_w[c - 1]) == K_ILL);
            chk("m_reg2loc", 32'(bus.Reg2Loc_Ctrl), 32'((kw == K_ADDS) || (kw == K_SUBS)));
            chk("m_uncond", 32'(bus.UnCondBr_Ctrl), 32'(kw == K_B));
            chk("m_brtaken", 32'(bus.BrTaken_Ctrl), 32'(br));
            chk("m_fw1", 32'(bus.FW_RegFile1_Ctrl), 32'(fw_model(u1, id_w[c][9:5], ex_w[c], mem_w[c])));
            chk("m_fw2", 32'(bus.FW_RegFile2_Ctrl), 32'(fw_model(u2, s2, ex_w[c], mem_w[c])));
            chk("m_hazard", 32'(bus.load_use_hazard), 32'(haz));
            chk("m_ex", 32'({bus.AluSrc_Ctrl, bus.IsImm_Ctrl, bus.ALUOp_Ctrl, bus.ALURes_Ctrl}), 32'(ce[10:4]));
            chk("m_mem", 32'({bus.WrEnable_Ctrl, bus.RdEnable_Ctrl, bus.MemReg_Ctrl}), 32'(cm[3:1]));
            chk("m_regwrite", 32'(bus.RegWrite_Ctrl), 32'(cw));
            chk("m_illegal", 32'(bus.illegal_instr), 32'(ill));
            chk("m_flags_q", 32'(bus.flags_q), 32'(flags_m));
        end
        if (active) begin
            ke = kind(ex_w[cur]);
            if (rst_f[cur]) flags_m = 4'b0000;
            else if ((ke == K_ADDS) || (ke == K_SUBS)) flags_m = alu_f[cur];
        end
    end

    initial begin
        reset = 1'b1;
        bus.instruction_out = 32'h0;
        bus.instr_one_clock_before = 32'h0;
        bus.instr_two_clocks_before = 32'h0;
        bus.ALUFlags = 4'h0;
        bus.IsRegRdZero = 1'b0;

        step(32'h0, D, 1'b0, 1'b1);                               // c0
        step(32'h0, D, 1'b0, 1'b1);                               // c1
        chk("rst_ex", 32'({bus.AluSrc_Ctrl, bus.ALUOp_Ctrl}), 32'h0);
        step(enc_addi(5'd1, 5'd31, 12'd5), D, 1'b0, 1'b0);        // c2
        step(enc_r(1'b0, 5'd2, 5'd1, 5'd1), D, 1'b0, 1'b0);       // c3
        chk("addi_adds_fw1", 32'(bus.FW_RegFile1_Ctrl), 32'h1);
        chk("addi_adds_fw2", 32'(bus.FW_RegFile2_Ctrl), 32'h1);
        chk("addi_ex", 32'({bus.AluSrc_Ctrl, bus.IsImm_Ctrl, bus.ALUOp_Ctrl}), 32'b1_1_010);
        step(32'h0, D, 1'b0, 1'b0);                               // c4
        step(32'h0, D, 1'b0, 1'b0);                               // c5
        chk("addi_regwrite", 32'(bus.RegWrite_Ctrl), 32'h1);
        step(enc_ldur(5'd3, 5'd0, 9'd0), D, 1'b0, 1'b0);          // c6
        step(32'h0, D, 1'b0, 1'b0);                               // c7
        step(enc_stur(5'd3, 5'd0, 9'd8), D, 1'b0, 1'b0);          // c8
        chk("ldur_stur_fw2", 32'(bus.FW_RegFile2_Ctrl), 32'h2);
        chk("ldur_mem", 32'({bus.RdEnable_Ctrl, bus.MemReg_Ctrl}), 32'b11);
        step(32'h0, D, 1'b0, 1'b0);                               // c9
        step(32'h0, D, 1'b0, 1'b0);                               // c10
        chk("stur_wren", 32'(bus.WrEnable_Ctrl), 32'h1);
        step(enc_ldur(5'd3, 5'd0, 9'd0), D, 1'b0, 1'b0);          // c11
        step(enc_r(1'b0, 5'd5, 5'd3, 5'd1), D, 1'b0, 1'b0);       // c12
        chk("loaduse_haz", 32'(bus.load_use_hazard), 32'h1);
        chk("loaduse_fw1", 32'(bus.FW_RegFile1_Ctrl), 32'h0);
        step(enc_r(1'b1, 5'd4, 5'd1, 5'd2), D, 1'b0, 1'b0);       // c13
        step(enc_bcond(5'b01011), 4'b1000, 1'b0, 1'b0);           // c14
        chk("blt_live_taken", 32'(bus.BrTaken_Ctrl), 32'h1);
        step(enc_bcond(5'b01011), D, 1'b0, 1'b0);                 // c15
        chk("blt_stored_taken", 32'(bus.BrTaken_Ctrl), 32'h1);
        chk("flags_q_1000", 32'(bus.flags_q), 32'h8);
        step(enc_r(1'b1, 5'd4, 5'd1, 5'd2), D, 1'b0, 1'b0);       // c16
        step(enc_bcond(5'b01011), 4'b1001, 1'b0, 1'b0);           // c17
        chk("blt_not_taken", 32'(bus.BrTaken_Ctrl), 32'h0);
        step(32'h0, D, 1'b0, 1'b0);                               // c18
        chk("flags_q_1001", 32'(bus.flags_q), 32'h9);
        step(enc_cbz(5'd7), D, 1'b1, 1'b0);                       // c19
        chk("cbz_taken", 32'({bus.BrTaken_Ctrl, bus.UnCondBr_Ctrl}), 32'b10);
        step(enc_addi(5'd8, 5'd8, 12'd1), D, 1'b0, 1'b0);         // c20
        step({6'b000101, 26'd4}, D, 1'b0, 1'b0);                  // c21
        chk("b_taken", 32'({bus.BrTaken_Ctrl, bus.UnCondBr_Ctrl}), 32'b11);
        chk("slot_ex", 32'(bus.AluSrc_Ctrl), 32'h1);
        step(enc_r(1'b0, 5'd9, 5'd8, 5'd8), D, 1'b0, 1'b0);       // c22
        chk("mem_fw", 32'({bus.FW_RegFile1_Ctrl, bus.FW_RegFile2_Ctrl}), 32'b1010);
        step(enc_addi(5'd31, 5'd1, 12'd3), D, 1'b0, 1'b0);        // c23
        step(enc_r(1'b0, 5'd10, 5'd31, 5'd31), D, 1'b0, 1'b0);    // c24
        chk("x31_fw", 32'({bus.FW_RegFile1_Ctrl, bus.FW_RegFile2_Ctrl}), 32'h0);
        step(32'hFFFF_FFFF, D, 1'b0, 1'b0);                       // c25
        step(32'h0, D, 1'b0, 1'b0);                               // c26
        chk("illegal_pulse", 32'(bus.illegal_instr), 32'h1);
        chk("illegal_no_ex", 32'({bus.AluSrc_Ctrl, bus.ALUOp_Ctrl}), 32'h0);
        step(enc_addi(5'd12, 5'd1, 12'd1), D, 1'b0, 1'b0);        // c27
        chk("illegal_end", 32'(bus.illegal_instr), 32'h0);
        step(enc_stur(5'd3, 5'd0, 9'd8), D, 1'b0, 1'b0);          // c28
        step(32'h0, D, 1'b0, 1'b1);                               // c29
        step(32'h0, D, 1'b0, 1'b0);                               // c30
        chk("rst_wren", 32'(bus.WrEnable_Ctrl), 32'h0);
        chk("rst_regwrite", 32'(bus.RegWrite_Ctrl), 32'h0);
        chk("rst_flags", 32'(bus.flags_q), 32'h0);
        step(enc_cbz(5'd7), D, 1'b0, 1'b0);                       // c31
        step(enc_bcond(5'b00000), D, 1'b0, 1'b0);                 // c32
        step(32'h0, D, 1'b0, 1'b0);                               // c33
        step(enc_addi(5'd6, 5'd31, 12'd1), D, 1'b0, 1'b0);        // c34
        step(enc_addi(5'd6, 5'd6, 12'd1), D, 1'b0, 1'b0);         // c35
        step(enc_r(1'b0, 5'd7, 5'd6, 5'd6), D, 1'b0, 1'b0);       // c36
        chk("ex_priority", 32'(bus.FW_RegFile1_Ctrl), 32'h1);
        step(enc_stur(5'd6, 5'd6, 9'd0), D, 1'b0, 1'b0);          // c37
        step(32'h0, D, 1'b0, 1'b0);
        step(32'h0, D, 1'b0, 1'b0);
        step(32'h0, D, 1'b0, 1'b0);
        active = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
